// File: rtl/axi_ram_pkg.sv
// Shared AXI RAM front-end definitions.
// Burst/response encodings and the transfer-size clamp.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  function automatic logic [2:0] clamp_size(
    input logic [2:0] size,
    input logic [2:0] max_size
  );
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi_ram_b_pipe.sv
// Optional register slice for an AXI response channel.
// PIPELINE=0 is a wire-through; PIPELINE=1 keeps full throughput.
module axi_ram_b_pipe #(
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 1,
  parameter int PIPELINE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic [USER_WIDTH-1:0] in_user,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  out_valid,
  input  logic                  out_ready
);

  if (PIPELINE != 0) begin : g_reg
    logic                  valid_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [USER_WIDTH-1:0] user_q;
    logic                  load;

    // Slot frees up in the same cycle it drains.
    assign load = !valid_q || out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= in_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (load && in_valid) begin
        id_q   <= in_id;
        user_q <= in_user;
      end
    end

    assign in_ready  = load;
    assign out_valid = valid_q;
    assign out_id    = id_q;
    assign out_user  = user_q;
  end else begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst};
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_id    = in_id;
    assign out_user  = in_user;
  end

endmodule

// File: rtl/axi_ram_wr_if.sv
// AXI4 write front-end: expands AW bursts into per-beat RAM
// write commands and returns completions on the B channel.
module axi_ram_wr_if
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int AWUSER_ENABLE   = 0,
  parameter int AWUSER_WIDTH    = 1,
  parameter int WUSER_ENABLE    = 0,
  parameter int WUSER_WIDTH     = 1,
  parameter int BUSER_ENABLE    = 0,
  parameter int BUSER_WIDTH     = 1,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     ram_wr_cmd_id,
  output logic [ADDR_WIDTH-1:0]   ram_wr_cmd_addr,
  output logic                    ram_wr_cmd_lock,
  output logic [3:0]              ram_wr_cmd_cache,
  output logic [2:0]              ram_wr_cmd_prot,
  output logic [3:0]              ram_wr_cmd_qos,
  output logic [3:0]              ram_wr_cmd_region,
  output logic [AWUSER_WIDTH-1:0] ram_wr_cmd_auser,
  output logic [DATA_WIDTH-1:0]   ram_wr_cmd_data,
  output logic [STRB_WIDTH-1:0]   ram_wr_cmd_strb,
  output logic [WUSER_WIDTH-1:0]  ram_wr_cmd_wuser,
  output logic                    ram_wr_cmd_en,
  output logic                    ram_wr_cmd_last,
  input  logic                    ram_wr_cmd_ready,
  input  logic [ID_WIDTH-1:0]     ram_wr_resp_id,
  input  logic [BUSER_WIDTH-1:0]  ram_wr_resp_user,
  input  logic                    ram_wr_resp_valid,
  output logic                    ram_wr_resp_ready
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

  if ((DATA_WIDTH % STRB_WIDTH) != 0 ||
      (STRB_WIDTH & (STRB_WIDTH - 1)) != 0) begin : g_bad_strb
    $error("axi_ram_wr_if: bad STRB_WIDTH");
  end

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                  state_q, state_d;
  logic                    awready_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    lock_q;
  logic [3:0]              cache_q;
  logic [2:0]              prot_q;
  logic [3:0]              qos_q;
  logic [3:0]              region_q;
  logic [AWUSER_WIDTH-1:0] auser_q;
  logic [7:0]              count_q, count_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    aw_hs;
  logic                    beat;

  assign aw_hs = s_axi_awvalid && awready_q;
  assign beat  = (state_q == ST_BURST) &&
                 s_axi_wvalid && ram_wr_cmd_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    size_d  = size_q;
    burst_d = burst_q;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          state_d = ST_BURST;
          addr_d  = s_axi_awaddr;
          count_d = s_axi_awlen;
          size_d  = clamp_size(s_axi_awsize, MAX_SIZE);
          burst_d = s_axi_awburst;
        end
      end
      ST_BURST: begin
        if (beat) begin
          // WRAP deliberately advances like INCR.
          if (burst_q != BURST_FIXED) begin
            addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
          end
          count_d = count_q - 8'd1;
          if (count_q == 8'd0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    count_q <= count_d;
    size_q  <= size_d;
    burst_q <= burst_d;
    if (aw_hs) begin
      id_q     <= s_axi_awid;
      lock_q   <= s_axi_awlock;
      cache_q  <= s_axi_awcache;
      prot_q   <= s_axi_awprot;
      qos_q    <= s_axi_awqos;
      region_q <= s_axi_awregion;
      auser_q  <= s_axi_awuser;
    end
  end

  assign s_axi_awready     = awready_q;
  assign s_axi_wready      = (state_q == ST_BURST) && ram_wr_cmd_ready;
  assign ram_wr_cmd_en     = (state_q == ST_BURST) && s_axi_wvalid;
  assign ram_wr_cmd_last   = (count_q == 8'd0);
  assign ram_wr_cmd_id     = id_q;
  assign ram_wr_cmd_addr   = addr_q;
  assign ram_wr_cmd_lock   = lock_q;
  assign ram_wr_cmd_cache  = cache_q;
  assign ram_wr_cmd_prot   = prot_q;
  assign ram_wr_cmd_qos    = qos_q;
  assign ram_wr_cmd_region = region_q;
  assign ram_wr_cmd_auser  = (AWUSER_ENABLE != 0) ? auser_q : '0;
  assign ram_wr_cmd_data   = s_axi_wdata;
  assign ram_wr_cmd_strb   = s_axi_wstrb;
  assign ram_wr_cmd_wuser  = (WUSER_ENABLE != 0) ? s_axi_wuser : '0;

  logic unused_ok;
  assign unused_ok = ^{s_axi_wlast, auser_q, s_axi_wuser,
                       ram_wr_resp_user};

  logic [BUSER_WIDTH-1:0] resp_user;
  assign resp_user = (BUSER_ENABLE != 0) ? ram_wr_resp_user : '0;

  axi_ram_b_pipe #(
    .ID_WIDTH   (ID_WIDTH),
    .USER_WIDTH (BUSER_WIDTH),
    .PIPELINE   (PIPELINE_OUTPUT)
  ) u_b_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_id     (ram_wr_resp_id),
    .in_user   (resp_user),
    .in_valid  (ram_wr_resp_valid),
    .in_ready  (ram_wr_resp_ready),
    .out_id    (s_axi_bid),
    .out_user  (s_axi_buser),
    .out_valid (s_axi_bvalid),
    .out_ready (s_axi_bready)
  );

  assign s_axi_bresp = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_wr_if.sv
// Randomized bench for axi_ram_wr_if with a burst-address
// reference model and an in-order B-channel scoreboard.
module tb_axi_ram_wr_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awid = '0;
  logic [15:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awlock = 1'b0;
  logic [3:0]  awcache = '0, awqos = '0, awregion = '0;
  logic [2:0]  awprot = '0;
  logic [0:0]  awuser = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic [0:0]  wuser = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic [0:0]  buser;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_addr;
  logic        cmd_lock;
  logic [3:0]  cmd_cache, cmd_qos, cmd_region;
  logic [2:0]  cmd_prot;
  logic [0:0]  cmd_auser, cmd_wuser;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        cmd_en, cmd_last;
  logic        cmd_ready = 1'b1;
  logic [7:0]  resp_id = '0;
  logic [0:0]  resp_user = '0;
  logic        resp_valid = 1'b0;
  logic        resp_ready;

  always #5 clk = ~clk;

  axi_ram_wr_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8),
    .PIPELINE_OUTPUT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awprot(awprot), .s_axi_awqos(awqos),
    .s_axi_awregion(awregion), .s_axi_awuser(awuser),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wuser(wuser), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .ram_wr_cmd_id(cmd_id), .ram_wr_cmd_addr(cmd_addr),
    .ram_wr_cmd_lock(cmd_lock), .ram_wr_cmd_cache(cmd_cache),
    .ram_wr_cmd_prot(cmd_prot), .ram_wr_cmd_qos(cmd_qos),
    .ram_wr_cmd_region(cmd_region), .ram_wr_cmd_auser(cmd_auser),
    .ram_wr_cmd_data(cmd_data), .ram_wr_cmd_strb(cmd_strb),
    .ram_wr_cmd_wuser(cmd_wuser), .ram_wr_cmd_en(cmd_en),
    .ram_wr_cmd_last(cmd_last), .ram_wr_cmd_ready(cmd_ready),
    .ram_wr_resp_id(resp_id), .ram_wr_resp_user(resp_user),
    .ram_wr_resp_valid(resp_valid), .ram_wr_resp_ready(resp_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mirror_bad;
  bit aw_after;
  bit fix_data = 0;

  logic [15:0] q_addr[$];
  logic        q_last[$];
  logic [7:0]  q_id[$];
  logic [31:0] q_data[$], x_data[$];
  logic [3:0]  q_strb[$], x_strb[$];

  // Beat i of a burst: FIXED stays put, others step by the clamped size.
  function automatic logic [15:0] exp_addr(
    input logic [15:0] base, input logic [2:0] sz,
    input logic [1:0] bt, input int i);
    int s;
    s = (sz > 3'd2) ? 2 : int'(sz);
    if (bt == 2'b00) return base;
    return 16'((int'(base) + i * (1 << s)) % 65536);
  endfunction

  // Invariant: tasks start and end one time unit after a rising edge.
  task automatic send_aw(input logic [15:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    bit got = 0;
    awid = 8'($urandom); awaddr = a; awlen = len;
    awsize = sz; awburst = bt; awcache = 4'($urandom);
    awprot = 3'($urandom); awqos = 4'($urandom);
    awregion = 4'($urandom); awlock = 1'($urandom);
    awvalid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (awready) got = 1;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL aw_timeout: awready got 0 want 1");
    end
  endtask

  task automatic run_burst(input logic [15:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt,
                           input bit early_last, input int rmode);
    int acc = 0;
    int cyc = 0;
    q_addr = {}; q_last = {}; q_id = {};
    q_data = {}; x_data = {}; q_strb = {}; x_strb = {};
    mirror_bad = 0;
    send_aw(a, len, sz, bt);
    while (acc <= int'(len) && cyc < 300) begin
      wvalid = (rmode == 2) ? 1'($urandom) : 1'b1;
      cmd_ready = (rmode == 0) ? 1'b1 :
                  (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      wdata = fix_data ? 32'hDEADBEEF : $urandom;
      wstrb = fix_data ? 4'hF : 4'($urandom);
      wlast = early_last ? (acc == 0) : (acc == int'(len));
      @(negedge clk);
      if (wready !== cmd_ready) mirror_bad++;
      if (cmd_en !== wvalid) mirror_bad++;
      if (wvalid && wready) begin
        q_addr.push_back(cmd_addr); q_last.push_back(cmd_last);
        q_id.push_back(cmd_id);
        q_data.push_back(cmd_data); x_data.push_back(wdata);
        q_strb.push_back(cmd_strb); x_strb.push_back(wstrb);
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wvalid = 1'b0; wlast = 1'b0; cmd_ready = 1'b1;
    @(negedge clk);
    aw_after = awready;
    @(posedge clk); #1;
    n_cmp++;
    if (acc <= int'(len)) begin
      n_bad++;
      $display("FAIL w_timeout: beats got %0d want %0d", acc, len + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({awready, wready, cmd_en, bvalid} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want 0000",
               {awready, wready, cmd_en, bvalid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (awready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_aw_early: got %b want 0", awready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (awready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_aw_up: got %b want 1", awready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    fix_data = 1;
    run_burst(16'h0100, 8'd0, 3'd2, 2'b01, 0, 0);
    fix_data = 0;
    n_cmp++;
    if (q_addr.size() != 1) begin
      n_bad++;
      $display("FAIL single_cnt: got %0d want 1", q_addr.size());
    end else begin
      n_cmp += 4;
      if (q_addr[0] !== 16'h0100) begin
        n_bad++;
        $display("FAIL single_addr: got %h want 0100", q_addr[0]);
      end
      if (q_last[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL single_last: got %b want 1", q_last[0]);
      end
      if (q_data[0] !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL single_data: got %h want deadbeef", q_data[0]);
      end
      if (q_strb[0] !== 4'hF) begin
        n_bad++;
        $display("FAIL single_strb: got %h want f", q_strb[0]);
      end
    end
    n_cmp++;
    if (aw_after !== 1'b1) begin
      n_bad++;
      $display("FAIL single_awready: got %b want 1", aw_after);
    end
  endtask

  task automatic test_incr_toggle();
    run_burst(16'h0010, 8'd3, 3'd2, 2'b01, 0, 1);
    n_cmp++;
    if (q_addr.size() != 4) begin
      n_bad++;
      $display("FAIL incr_cnt: got %0d want 4", q_addr.size());
    end
    foreach (q_addr[i]) begin
      n_cmp += 2;
      if (q_addr[i] !== exp_addr(16'h0010, 3'd2, 2'b01, i)) begin
        n_bad++;
        $display("FAIL incr_addr%0d: got %h want %h", i, q_addr[i],
                 exp_addr(16'h0010, 3'd2, 2'b01, i));
      end
      if (q_last[i] !== (i == 3)) begin
        n_bad++;
        $display("FAIL incr_last%0d: got %b want %b", i, q_last[i], i == 3);
      end
    end
    n_cmp++;
    if (mirror_bad != 0) begin
      n_bad++;
      $display("FAIL incr_mirror: got %0d want 0", mirror_bad);
    end
  endtask

  task automatic test_size_fixed();
    logic [15:0] base[2];
    logic [1:0]  bt[2];
    base[0] = 16'h0000; bt[0] = 2'b01;
    base[1] = 16'h0040; bt[1] = 2'b00;
    for (int t = 0; t < 2; t++) begin
      run_burst(base[t], 8'd1, 3'd5, bt[t], 0, 0);
      n_cmp++;
      if (q_addr.size() != 2) begin
        n_bad++;
        $display("FAIL clamp_cnt%0d: got %0d want 2", t, q_addr.size());
      end
      foreach (q_addr[i]) begin
        n_cmp++;
        if (q_addr[i] !== exp_addr(base[t], 3'd5, bt[t], i)) begin
          n_bad++;
          $display("FAIL clamp_addr%0d_%0d: got %h want %h", t, i,
                   q_addr[i], exp_addr(base[t], 3'd5, bt[t], i));
        end
      end
    end
  endtask

  task automatic test_wrap_wlast();
    run_burst(16'hFFFC, 8'd1, 3'd2, 2'b01, 1, 0);
    n_cmp++;
    if (q_addr.size() != 2) begin
      n_bad++;
      $display("FAIL wrap_cnt: got %0d want 2", q_addr.size());
    end
    foreach (q_addr[i]) begin
      n_cmp += 2;
      if (q_addr[i] !== exp_addr(16'hFFFC, 3'd2, 2'b01, i)) begin
        n_bad++;
        $display("FAIL wrap_addr%0d: got %h want %h", i, q_addr[i],
                 exp_addr(16'hFFFC, 3'd2, 2'b01, i));
      end
      if (q_last[i] !== (i == 1)) begin
        n_bad++;
        $display("FAIL wrap_last%0d: got %b want %b", i, q_last[i], i == 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      logic [15:0] a;
      logic [7:0]  len;
      logic [2:0]  sz;
      logic [1:0]  bt;
      logic [7:0]  id;
      a = (n % 3 == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15))
                       : 16'($urandom);
      len = 8'($urandom_range(0, 7));
      sz = 3'($urandom);
      bt = 2'($urandom_range(0, 2));
      run_burst(a, len, sz, bt, 0, 2);
      id = awid;
      n_cmp++;
      if (q_addr.size() != int'(len) + 1) begin
        n_bad++;
        $display("FAIL b2b_cnt%0d: got %0d want %0d", n,
                 q_addr.size(), len + 1);
      end
      foreach (q_addr[i]) begin
        n_cmp += 4;
        if (q_addr[i] !== exp_addr(a, sz, bt, i)) begin
          n_bad++;
          $display("FAIL b2b_addr%0d_%0d: got %h want %h", n, i,
                   q_addr[i], exp_addr(a, sz, bt, i));
        end
        if (q_last[i] !== (i == int'(len))) begin
          n_bad++;
          $display("FAIL b2b_last%0d_%0d: got %b", n, i, q_last[i]);
        end
        if ({q_data[i], q_strb[i]} !== {x_data[i], x_strb[i]}) begin
          n_bad++;
          $display("FAIL b2b_data%0d_%0d: got %h/%h want %h/%h", n, i,
                   q_data[i], q_strb[i], x_data[i], x_strb[i]);
        end
        if (q_id[i] !== id) begin
          n_bad++;
          $display("FAIL b2b_id%0d_%0d: got %h want %h", n, i, q_id[i], id);
        end
      end
      n_cmp++;
      if (mirror_bad != 0) begin
        n_bad++;
        $display("FAIL b2b_mirror%0d: got %0d want 0", n, mirror_bad);
      end
    end
  endtask

  task automatic test_b_pipe();
    bready = 1'b0; resp_valid = 1'b1; resp_id = 8'h5A; resp_user = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({resp_ready, bvalid} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_empty: got %b want 10", {resp_ready, bvalid});
    end
    @(posedge clk); #1;
    resp_id = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({bvalid, bid, bresp, buser, resp_ready} !==
          {1'b1, 8'h5A, 2'b00, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold: got v%b id%h r%h u%b rdy%b", bvalid, bid,
                 bresp, buser, resp_ready);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bvalid, bid, resp_ready} !== {1'b1, 8'h5A, 1'b1}) begin
      n_bad++;
      $display("FAIL bp_first: got v%b id%h rdy%b", bvalid, bid, resp_ready);
    end
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bvalid, bid} !== {1'b1, 8'hA5}) begin
      n_bad++;
      $display("FAIL bp_second: got v%b id%h want 1 a5", bvalid, bid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drained: got %b want 0", bvalid);
    end
    @(posedge clk); #1;
    bready = 1'b0; resp_user = 1'b0;
  endtask

  task automatic test_b_random();
    logic [7:0] exp_q[$];
    int sent = 0, got = 0, stall = 0;
    for (int c = 0; c < 240; c++) begin
      bit hs_in;
      if (c < 200) begin
        if (!resp_valid) begin
          resp_valid = 1'($urandom);
          resp_id = 8'($urandom);
        end
        bready = 1'($urandom);
      end else begin
        bready = 1'b1;
      end
      @(negedge clk);
      hs_in = resp_valid && resp_ready;
      if (bready && !resp_ready) stall++;
      if (hs_in) begin
        exp_q.push_back(resp_id);
        sent++;
      end
      if (bvalid && bready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL brand_spurious: got id %h want none", bid);
        end else if (bid !== exp_q[0]) begin
          n_bad++;
          $display("FAIL brand_order: got %h want %h", bid, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      @(posedge clk); #1;
      if (hs_in) resp_valid = 1'b0;
      if (c >= 199) resp_valid = 1'b0;
    end
    n_cmp += 2;
    if (got != sent || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL brand_count: got %0d want %0d", got, sent);
    end
    if (stall != 0) begin
      n_bad++;
      $display("FAIL brand_throughput: got %0d stalls want 0", stall);
    end
    bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    send_aw(16'h0200, 8'd3, 3'd2, 2'b01);
    wvalid = 1'b1; cmd_ready = 1'b1;
    resp_valid = 1'b1; resp_id = 8'h33; bready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    resp_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_en, wready, bvalid, awready} !== 4'b0) begin
      n_bad++;
      $display("FAIL rmid_outs: got %b want 0000",
               {cmd_en, wready, bvalid, awready});
    end
    @(posedge clk); #1;
    rst = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (awready !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_aw_early: got %b want 0", awready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({awready, bvalid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rmid_aw_up: got %b want 10", {awready, bvalid});
    end
    @(posedge clk); #1;
    a = 16'($urandom);
    run_burst(a, 8'd2, 3'd1, 2'b01, 0, 2);
    n_cmp++;
    if (q_addr.size() != 3) begin
      n_bad++;
      $display("FAIL rmid_cnt: got %0d want 3", q_addr.size());
    end
    foreach (q_addr[i]) begin
      n_cmp++;
      if (q_addr[i] !== exp_addr(a, 3'd1, 2'b01, i)) begin
        n_bad++;
        $display("FAIL rmid_addr%0d: got %h want %h", i, q_addr[i],
                 exp_addr(a, 3'd1, 2'b01, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_toggle();
    test_size_fixed();
    test_wrap_wlast();
    test_back_to_back();
    test_b_pipe();
    test_b_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
